// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data and memory-side handshake signals of mem_port_arbiter.
// master: the arbiter's view; slave: the pipeline/memory environment's view.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 64,
  parameter int unsigned DW = 64
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [1:0]    dm_size;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [1:0]    mem_size;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;

  modport master (
    input  if_req, if_addr, if_flush,
    output if_gnt, if_rvalid, if_rdata,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_size,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_size,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    output if_req, if_addr, if_flush,
    input  if_gnt, if_rvalid, if_rdata,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_size,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_size,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the MEM stage, one transaction
// in flight; data side has priority, a starvation counter guarantees fetch progress.
module mem_port_arbiter #(
  parameter int unsigned AW           = 64,
  parameter int unsigned DW           = 64,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst_n,
  mem_port_arbiter_if.master bus
);
  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

  state_t        state;
  owner_t        owner;
  logic [CW-1:0] starve_cnt;
  logic          drop;

  logic          mem_req_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [1:0]    mem_size_q;
  logic          if_rvalid_q;
  logic          dm_rvalid_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] dm_rdata_q;

  logic if_elig;
  logic both_elig;
  logic dm_win;
  logic if_win;

  // Same-cycle arbitration in IDLE; grants are suppressed while reset is asserted.
  always_comb begin
    if_elig   = bus.if_req & ~bus.if_flush;
    both_elig = if_elig & bus.dm_req;
    dm_win    = 1'b0;
    if_win    = 1'b0;
    if (rst_n && state == S_IDLE) begin
      dm_win = bus.dm_req & (~if_elig | (starve_cnt < CW'(STARVE_LIMIT)));
      if_win = if_elig & ~dm_win;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      owner       <= OWN_NONE;
      starve_cnt  <= '0;
      drop        <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_size_q  <= 2'b00;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;

      // A flushed fetch still runs to completion on the bus; only its response is dropped.
      if (owner == OWN_IF && bus.if_flush && state != S_IDLE) begin
        drop <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (dm_win) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.dm_we;
            mem_addr_q  <= bus.dm_addr;
            mem_wdata_q <= bus.dm_wdata;
            mem_size_q  <= bus.dm_size;
            owner       <= OWN_DM;
            state       <= S_REQ;
            if (both_elig && starve_cnt != CW'(STARVE_LIMIT)) begin
              starve_cnt <= starve_cnt + CW'(1);
            end
          end else if (if_win) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.if_addr;
            mem_wdata_q <= '0;
            mem_size_q  <= 2'b10;
            owner       <= OWN_IF;
            state       <= S_REQ;
            starve_cnt  <= '0;
          end
        end
        S_REQ: begin
          if (bus.mem_gnt) begin
            mem_req_q <= 1'b0;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.mem_rvalid) begin
            if (owner == OWN_DM) begin
              dm_rvalid_q <= 1'b1;
              dm_rdata_q  <= bus.mem_rdata;
            end else if (owner == OWN_IF && !drop && !bus.if_flush) begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= bus.mem_rdata;
            end
            drop  <= 1'b0;
            owner <= OWN_NONE;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.if_gnt    = if_win;
  assign bus.dm_gnt    = dm_win;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rvalid = dm_rvalid_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_size  = mem_size_q;
endmodule
